// File: rtl/riscv_pkg.sv
// Shared core package: branch-predictor defaults and saturating-arithmetic helpers.
package riscv_pkg;

    localparam int BPRED_CTR_W_DEFAULT = 2;

    // Saturating increment towards max_v; values are carried in a 32-bit container.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// One CTR_W-bit saturating direction counter with load/inc/dec enables (load has priority).
module bpred_sat_ctr
    import riscv_pkg::*;
#(
    parameter int CTR_W = BPRED_CTR_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CTR_W-1:0] ctr_o
);

    localparam logic [31:0] CTR_MAX = 32'((64'd1 << CTR_W) - 64'd1);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_i) begin
            ctr_d = load_val_i;
        end else if (inc_i) begin
            ctr_d = CTR_W'(sat_inc(32'(ctr_q), CTR_MAX));
        end else if (dec_i) begin
            ctr_d = CTR_W'(sat_dec(32'(ctr_q)));
        end else begin
            ctr_d = ctr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/bpred_bimodal_btb.sv
// Direct-mapped BTB with partial tags and per-entry saturating direction counters.
// Optional statistics counters are enabled with the BPRED_STATS_EN macro.
module bpred_bimodal_btb
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = BPRED_CTR_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_hit_o,
    output logic            fetch_taken_o,
    output logic [XLEN-1:0] fetch_target_o,
    input  logic            ex_valid_i,
    input  logic            ex_is_branch_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]     stat_updates_o,
    output logic [31:0]     stat_mispred_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(1) << (CTR_W - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } bpred_entry_t;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tags_q    [ENTRIES];
    logic [XLEN-1:0]    targets_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_s     [ENTRIES];

    // PC bit 0 is ignored so that compressed instructions index like full ones.
    logic [IDX_W-1:0] f_idx_s, ex_idx_s;
    logic [TAG_W-1:0] f_tag_s, ex_tag_s;
    assign f_idx_s  = fetch_pc_i[IDX_W:1];
    assign f_tag_s  = fetch_pc_i[IDX_W+TAG_W:IDX_W+1];
    assign ex_idx_s = ex_pc_i[IDX_W:1];
    assign ex_tag_s = ex_pc_i[IDX_W+TAG_W:IDX_W+1];

    bpred_entry_t rd_e_s;
    always_comb begin
        rd_e_s.valid  = valid_q[f_idx_s];
        rd_e_s.tag    = tags_q[f_idx_s];
        rd_e_s.target = targets_q[f_idx_s];
        rd_e_s.ctr    = ctr_s[f_idx_s];
    end

    assign fetch_hit_o    = rd_e_s.valid && (rd_e_s.tag == f_tag_s);
    assign fetch_taken_o  = fetch_hit_o && rd_e_s.ctr[CTR_W-1];
    assign fetch_target_o = fetch_hit_o ? rd_e_s.target : '0;

    logic train_s, upd_s, ex_hit_s;
    assign train_s  = ex_valid_i && ex_is_branch_i;
    assign upd_s    = train_s && !flush_i;
    assign ex_hit_s = valid_q[ex_idx_s] && (tags_q[ex_idx_s] == ex_tag_s);

    // A taken update writes the same fields whether it hits (tag unchanged) or allocates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags_q[i]    <= '0;
                targets_q[i] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (upd_s && ex_taken_i) begin
            valid_q[ex_idx_s]   <= 1'b1;
            tags_q[ex_idx_s]    <= ex_tag_s;
            targets_q[ex_idx_s] <= ex_target_i;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel_s;
        assign sel_s = upd_s && (ex_idx_s == IDX_W'(g));
        bpred_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (sel_s && !ex_hit_s && ex_taken_i),
            .load_val_i (CTR_WEAK_TAKEN),
            .inc_i      (sel_s && ex_hit_s && ex_taken_i),
            .dec_i      (sel_s && ex_hit_s && !ex_taken_i),
            .ctr_o      (ctr_s[g])
        );
    end

`ifdef BPRED_STATS_EN
    logic [31:0] stat_updates_q, stat_mispred_q;

    // Statistics see every training event, including those discarded by a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_updates_q <= 32'd0;
            stat_mispred_q <= 32'd0;
        end else if (train_s) begin
            stat_updates_q <= sat_inc(stat_updates_q, 32'hFFFF_FFFF);
            if (ex_pred_taken_i != ex_taken_i) begin
                stat_mispred_q <= sat_inc(stat_mispred_q, 32'hFFFF_FFFF);
            end
        end
    end

    assign stat_updates_o = stat_updates_q;
    assign stat_mispred_o = stat_mispred_q;
`endif

    logic unused_s;
    assign unused_s = ^{fetch_pc_i, ex_pc_i, ex_pred_taken_i, rd_e_s};

endmodule
